// File: rtl/arb_pkg.sv
// Shared helpers for the arbiter and its return-path logic: ID sizing,
// one-hot validation and one-hot-to-binary encoding.
package arb_pkg;

  // Widest requester vector the helpers accept; callers zero-extend into this.
  localparam int MAX_REQ = 32;
  localparam int ENC_W   = 5;

  function automatic int id_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_onehot(input logic [MAX_REQ-1:0] v);
    return (v != '0) && ((v & (v - MAX_REQ'(1))) == '0);
  endfunction

  function automatic logic [ENC_W-1:0] onehot_to_bin(input logic [MAX_REQ-1:0] v);
    logic [ENC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) idx = idx | ENC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_resp_router_sync_fifo.sv
// Small synchronous FIFO holding grant IDs of outstanding commands.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign rdata_o = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_resp_router.sv
// Return-path router: tags each accepted command with its requester ID and
// routes in-order memory responses back to that requester one cycle later.
module arb_resp_router
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       grant_i,
  input  logic                     cmd_fire_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic [NUM_REQ-1:0]       rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic                     err_o
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [MAX_REQ-1:0] grant_ext;
  logic               grant_ok;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    head_id;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bad_cmd;
  logic               bad_rsp;

  assign grant_ext = MAX_REQ'(grant_i);
  assign grant_ok  = is_onehot(grant_ext);
  assign grant_id  = ID_W'(onehot_to_bin(grant_ext));

  // Full blocks a push even when a pop happens in the same cycle, and an
  // empty FIFO never bypasses a same-cycle push to the response side.
  assign push    = cmd_fire_i && grant_ok && !full;
  assign pop     = mem_rvalid_i && !empty;
  assign bad_cmd = cmd_fire_i && (!grant_ok || full);
  assign bad_rsp = mem_rvalid_i && empty;

  sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (grant_id),
    .rdata_o (head_id),
    .full_o  (full),
    .empty_o (empty),
    .count_o (pending_o)
  );

  assign stall_o = full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= pop ? (NUM_REQ'(1) << head_id) : '0;
      if (pop) rdata_o <= mem_rdata_i;
      if (bad_cmd || bad_rsp) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_resp_router.sv
// Directed self-checking bench for arb_resp_router (NUM_REQ=2, DEPTH=4).
module tb_arb_resp_router;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  grant_i;
  logic        cmd_fire_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic [2:0]  pending_o;
  logic        err_o;

  int vectors = 0;
  int errors  = 0;

  arb_resp_router #(.NUM_REQ(2), .DATA_W(32), .DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .grant_i      (grant_i),
    .cmd_fire_i   (cmd_fire_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .pending_o    (pending_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then release all strobes; checks happen 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cmd_fire_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    grant_i      = 2'b00;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic fire(input logic [1:0] g);
    grant_i    = g;
    cmd_fire_i = 1'b1;
    tick();
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rvalid_o, rdata_o, stall_o, pending_o, err_o} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state got rv=%b rd=%h st=%b pend=%0d err=%b exp all zero",
               rvalid_o, rdata_o, stall_o, pending_o, err_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    fire(2'b10);
    vectors++;
    if (pending_o !== 3'd1) begin
      errors++; $display("FAIL single_pending_1 got=%0d exp=1", pending_o);
    end
    tick();
    tick();
    respond(32'hDEAD_BEEF);
    vectors++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'hDEAD_BEEF || pending_o !== 3'd0) begin
      errors++;
      $display("FAIL single_resp got rv=%b rd=%h pend=%0d exp rv=10 rd=deadbeef pend=0",
               rvalid_o, rdata_o, pending_o);
    end
    tick();
    vectors++;
    if (rvalid_o !== 2'b00 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got rv=%b rd=%h err=%b exp rv=00 rd=deadbeef err=0",
               rvalid_o, rdata_o, err_o);
    end
  endtask

  task automatic test_ordering();
    logic [1:0]  g [4];
    logic [31:0] d [4];
    g = '{2'b01, 2'b10, 2'b01, 2'b10};
    d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    do_reset();
    for (int i = 0; i < 4; i++) fire(g[i]);
    vectors++;
    if (stall_o !== 1'b1 || pending_o !== 3'd4) begin
      errors++; $display("FAIL order_full got st=%b pend=%0d exp st=1 pend=4", stall_o, pending_o);
    end
    for (int i = 0; i < 4; i++) begin
      respond(d[i]);
      vectors++;
      if (rvalid_o !== g[i] || rdata_o !== d[i] || pending_o !== 3'(3 - i) || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL order_resp%0d got rv=%b rd=%h pend=%0d st=%b exp rv=%b rd=%h pend=%0d st=0",
                 i, rvalid_o, rdata_o, pending_o, stall_o, g[i], d[i], 3 - i);
      end
    end
    vectors++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL order_err got=%b exp=0", err_o);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    fire(2'b01);
    grant_i      = 2'b10;
    cmd_fire_i   = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    tick();
    vectors++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'h1234_5678 || pending_o !== 3'd1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_same got rv=%b rd=%h pend=%0d err=%b exp rv=01 rd=12345678 pend=1 err=0",
               rvalid_o, rdata_o, pending_o, err_o);
    end
    respond(32'h9ABC_DEF0);
    vectors++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'h9ABC_DEF0 || pending_o !== 3'd0) begin
      errors++;
      $display("FAIL pushpop_next got rv=%b rd=%h pend=%0d exp rv=10 rd=9abcdef0 pend=0",
               rvalid_o, rdata_o, pending_o);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] g [4];
    g = '{2'b01, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) fire(g[i]);
    grant_i      = 2'b10;
    cmd_fire_i   = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0011;
    tick();
    vectors++;
    if (err_o !== 1'b1 || pending_o !== 3'd3 || rvalid_o !== 2'b01) begin
      errors++;
      $display("FAIL overflow got err=%b pend=%0d rv=%b exp err=1 pend=3 rv=01", err_o, pending_o, rvalid_o);
    end
    for (int i = 1; i < 4; i++) begin
      respond(32'h0000_0011 + 32'(i));
      vectors++;
      if (rvalid_o !== g[i]) begin
        errors++; $display("FAIL overflow_drain%0d got rv=%b exp=%b", i, rvalid_o, g[i]);
      end
    end
    respond(32'h0000_00FF);
    vectors++;
    if (rvalid_o !== 2'b00 || rdata_o !== 32'h0000_0014 || pending_o !== 3'd0) begin
      errors++;
      $display("FAIL overflow_no5th got rv=%b rd=%h pend=%0d exp rv=00 rd=00000014 pend=0",
               rvalid_o, rdata_o, pending_o);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    grant_i      = 2'b01;
    cmd_fire_i   = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_5555;
    tick();
    vectors++;
    if (err_o !== 1'b1 || rvalid_o !== 2'b00 || pending_o !== 3'd1 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL underflow got err=%b rv=%b pend=%0d rd=%h exp err=1 rv=00 pend=1 rd=0",
               err_o, rvalid_o, pending_o, rdata_o);
    end
  endtask

  task automatic test_bad_grant();
    logic [1:0] bad [2];
    bad = '{2'b11, 2'b00};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      fire(2'b01);
      fire(bad[i]);
      vectors++;
      if (err_o !== 1'b1 || pending_o !== 3'd1) begin
        errors++;
        $display("FAIL bad_grant_%b got err=%b pend=%0d exp err=1 pend=1", bad[i], err_o, pending_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) fire(2'b10);
    fire(2'b11);
    vectors++;
    if (pending_o !== 3'd3 || err_o !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got pend=%0d err=%b exp pend=3 err=1", pending_o, err_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    vectors++;
    if (pending_o !== 3'd0 || err_o !== 1'b0 || rvalid_o !== 2'b00 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got pend=%0d err=%b rv=%b st=%b exp all zero",
               pending_o, err_o, rvalid_o, stall_o);
    end
    respond(32'hFEED_F00D);
    vectors++;
    if (err_o !== 1'b1 || rvalid_o !== 2'b00) begin
      errors++; $display("FAIL midrst_resp got err=%b rv=%b exp err=1 rv=00", err_o, rvalid_o);
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    grant_i      = 2'b00;
    cmd_fire_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    test_reset();
    test_single();
    test_ordering();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_bad_grant();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
